// File: rtl/button_pkg.sv
// Shared types for the button pulse scheduler: arbiter state encoding and id width helper.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FIRE = 2'b01,
        ST_GAP  = 2'b10
    } arb_state_t;

    // Width of a button index; a single-bit minimum keeps N=1 corner builds legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEFAULT = id_width(4);

endpackage

// File: rtl/button_pulse_scheduler_if.sv
// Button-side bundle of the scheduler: raw levels in, pulse strobe and status out.
interface button_pulse_scheduler_if #(
    parameter int N = 4
);
    import button_pkg::*;

    localparam int IDW = id_width(N);

    logic [N-1:0]   btn;
    logic           pulse;
    logic [IDW-1:0] pulse_id;
    logic [N-1:0]   pending;
    logic           overflow;

    modport master (
        output btn,
        input  pulse,
        input  pulse_id,
        input  pending,
        input  overflow
    );

    modport slave (
        input  btn,
        output pulse,
        output pulse_id,
        output pending,
        output overflow
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, counter debounce and a registered rising-edge press strobe.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          stable_next;
    logic          stable_d_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // The counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        stable_next = stable_reg;
        cnt_next    = cnt_reg;
        if (sync2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_next = sync2_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            press_reg    <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync1_reg    <= raw;
            sync2_reg    <= sync1_reg;
            stable_reg   <= stable_next;
            cnt_reg      <= cnt_next;
            stable_d_reg <= stable_reg;
            press_reg    <= stable_reg & ~stable_d_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/button_pulse_scheduler.sv
// Debounces N buttons, queues one press per button and serves them round-robin as
// single-cycle pulses separated by a fixed idle gap.
module button_pulse_scheduler
    import button_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    button_pulse_scheduler_if.slave    bus
);

    localparam int             IDW      = id_width(N);
    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

    arb_state_t     state_reg;
    arb_state_t     state_next;
    logic [N-1:0]   press;
    logic [N-1:0]   clear;
    logic [N-1:0]   drop;
    logic [N-1:0]   pending_reg;
    logic [N-1:0]   pending_next;
    logic           overflow_reg;
    logic           pulse_reg;
    logic [IDW-1:0] pulse_id_reg;
    logic [IDW-1:0] last_reg;
    logic [IDW-1:0] last_next;
    logic [GW-1:0]  gap_reg;
    logic [GW-1:0]  gap_next;
    logic [IDW-1:0] fire_id;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] cand;
    logic           pick_found;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .raw  (bus.btn[gi]),
                .press(press[gi])
            );

            // A fresh press beats the service clear, so a press in the FIRE cycle is kept.
            assign clear[gi]        = (state_reg == ST_FIRE) && (pulse_id_reg == IDW'(gi));
            assign drop[gi]         = press[gi] & pending_reg[gi] & ~clear[gi];
            assign pending_next[gi] = press[gi] | (pending_reg[gi] & ~clear[gi]);
        end
    endgenerate

    // Round-robin search starting just after the last served button, modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last_reg) + k) % N);
            if (!pick_found && pending_reg[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        last_next  = last_reg;
        fire_id    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_FIRE;
                    fire_id    = pick_id;
                end
            end
            ST_FIRE: begin
                last_next = pulse_id_reg;
                if (GAP_CYCLES == 0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next   = GAP_LOAD;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
            pulse_reg    <= 1'b0;
            pulse_id_reg <= '0;
            last_reg     <= LAST_RST;
            gap_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_reg | (|drop);
            pulse_reg    <= (state_next == ST_FIRE);
            pulse_id_reg <= fire_id;
            last_reg     <= last_next;
            gap_reg      <= gap_next;
        end
    end

    assign bus.pulse    = pulse_reg;
    assign bus.pulse_id = pulse_id_reg;
    assign bus.pending  = pending_reg;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_button_pulse_scheduler.sv
// Bench for button_pulse_scheduler: a GAP=2 and a GAP=0 build share one button stimulus and
// are compared every cycle with a behavioural model, plus directed scenario checks.
module tb_button_pulse_scheduler;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int NI  = 2;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] btn_r  = '0;
    bit           cmp_en = 1'b0;
    int           cyc    = 0;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    button_pulse_scheduler_if #(.N(N)) bi0 ();
    button_pulse_scheduler_if #(.N(N)) bi1 ();
    assign bi0.btn = btn_r;
    assign bi1.btn = btn_r;

    button_pulse_scheduler #(.N(N), .DEB_CYCLES(DEB), .GAP_CYCLES(2)) dut_gap2 (
        .clk(clk), .reset(reset), .bus(bi0)
    );
    button_pulse_scheduler #(.N(N), .DEB_CYCLES(DEB), .GAP_CYCLES(0)) dut_gap0 (
        .clk(clk), .reset(reset), .bus(bi1)
    );

    // ---------------- behavioural model ----------------
    int           gap_of [NI] = '{2, 0};
    bit [N-1:0]   m_s1, m_s2, m_stable, m_stable_d, m_press;
    bit           hist [N][DEB];      // last DEB synchronized samples, [0] newest
    bit [N-1:0]   m_pend [NI];
    bit           m_ovf [NI];
    bit           m_pulse [NI];
    int           m_id [NI];
    int           m_last [NI];
    int           m_cool [NI];        // idle cycles still owed after a pulse

    int log_id  [NI][$];
    int log_cyc [NI][$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0; m_press = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < DEB; k++) hist[i][k] = 1'b0;
        for (int d = 0; d < NI; d++) begin
            m_pend[d] = '0; m_ovf[d] = 1'b0; m_pulse[d] = 1'b0;
            m_id[d] = 0; m_last[d] = N - 1; m_cool[d] = 0;
        end
    endtask

    task automatic model_step();
        bit [N-1:0] clr;
        bit [N-1:0] new_stable;
        bit         all_diff;
        bit         got;
        int         pick;
        int         order[$];
        for (int d = 0; d < NI; d++) begin
            clr = '0;
            if (m_pulse[d]) clr[m_id[d]] = 1'b1;
            if ((m_press & m_pend[d] & ~clr) != '0) m_ovf[d] = 1'b1;
            if (m_pulse[d]) begin
                m_pulse[d] = 1'b0; m_id[d] = 0; m_cool[d] = gap_of[d];
            end else if (m_cool[d] > 0) begin
                m_cool[d]--;
            end else if (m_pend[d] != '0) begin
                order.delete();
                for (int j = m_last[d] + 1; j < N; j++) order.push_back(j);
                for (int j = 0; j <= m_last[d]; j++) order.push_back(j);
                got = 1'b0; pick = 0;
                foreach (order[q]) begin
                    if (!got && m_pend[d][order[q]]) begin got = 1'b1; pick = order[q]; end
                end
                m_pulse[d] = 1'b1; m_id[d] = pick; m_last[d] = pick;
            end
            m_pend[d] = (m_pend[d] & ~clr) | m_press;
        end
        // Level accepted once the last DEB samples all disagree with the current one.
        for (int i = 0; i < N; i++) begin
            for (int k = DEB - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = m_s2[i];
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) if (hist[i][k] == m_stable[i]) all_diff = 1'b0;
            new_stable[i] = all_diff ? m_s2[i] : m_stable[i];
        end
        m_press    = m_stable & ~m_stable_d;
        m_stable_d = m_stable;
        m_stable   = new_stable;
        m_s2       = m_s1;
        m_s1       = btn_r;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_step();
    end

    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            check_eq("pulse_g2",    32'(bi0.pulse),    32'(m_pulse[0]));
            check_eq("pulse_id_g2", 32'(bi0.pulse_id), 32'(m_id[0]));
            check_eq("pending_g2",  32'(bi0.pending),  32'(m_pend[0]));
            check_eq("overflow_g2", 32'(bi0.overflow), 32'(m_ovf[0]));
            check_eq("pulse_g0",    32'(bi1.pulse),    32'(m_pulse[1]));
            check_eq("pulse_id_g0", 32'(bi1.pulse_id), 32'(m_id[1]));
            check_eq("pending_g0",  32'(bi1.pending),  32'(m_pend[1]));
            check_eq("overflow_g0", 32'(bi1.overflow), 32'(m_ovf[1]));
        end
        if (!reset && bi0.pulse === 1'b1) begin
            log_id[0].push_back(int'(bi0.pulse_id)); log_cyc[0].push_back(cyc);
            $display("pulse gap2 id=%0d cyc=%0d pending=%b", bi0.pulse_id, cyc, bi0.pending);
        end
        if (!reset && bi1.pulse === 1'b1) begin
            log_id[1].push_back(int'(bi1.pulse_id)); log_cyc[1].push_back(cyc);
            $display("pulse gap0 id=%0d cyc=%0d pending=%b", bi1.pulse_id, cyc, bi1.pending);
        end
    end

    function automatic int id_at(input int d, input int k);
        return (k < log_id[d].size()) ? log_id[d][k] : -1;
    endfunction

    function automatic int cyc_at(input int d, input int k);
        return (k < log_cyc[d].size()) ? log_cyc[d][k] : -1000;
    endfunction

    task automatic clear_logs();
        for (int d = 0; d < NI; d++) begin log_id[d].delete(); log_cyc[d].delete(); end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int  t0;
    bit  found;

    initial begin
        model_reset();
        wait_cycles(3);
        #1;
        check_eq("rst_pulse",    32'(bi0.pulse),    0);
        check_eq("rst_pulse_id", 32'(bi0.pulse_id), 0);
        check_eq("rst_pending",  32'(bi0.pending),  0);
        check_eq("rst_overflow", 32'(bi0.overflow), 0);
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        wait_cycles(5);

        // Single press of button 2: one pulse, 2+DEB+1+2 cycles after the edge, none on release.
        clear_logs(); t0 = cyc; btn_r[2] = 1'b1;
        wait_cycles(20); btn_r[2] = 1'b0; wait_cycles(20);
        check_eq("single_count", log_id[0].size(), 1);
        check_eq("single_id", id_at(0, 0), 2);
        check_eq("single_latency", cyc_at(0, 0) - t0, 9);

        // Bounce on button 1 then a clean hold: exactly one pulse.
        clear_logs();
        for (int k = 0; k < 4; k++) begin btn_r[1] = (k % 2 == 0); wait_cycles(2); end
        btn_r[1] = 1'b1; wait_cycles(20); btn_r[1] = 1'b0; wait_cycles(20);
        check_eq("bounce_count", log_id[0].size(), 1);
        check_eq("bounce_id", id_at(0, 0), 1);

        // 3-cycle glitch is shorter than DEB: nothing.
        clear_logs(); btn_r[0] = 1'b1; wait_cycles(3); btn_r[0] = 1'b0; wait_cycles(20);
        check_eq("glitch_count", log_id[0].size() + log_id[1].size(), 0);

        // Overflow: button 1 re-pressed while still queued behind 2,3,0 (last served was 1).
        clear_logs(); btn_r = 4'b1111;
        wait_cycles(4); btn_r[1] = 1'b0; wait_cycles(7); btn_r[1] = 1'b1; wait_cycles(30);
        check_eq("ovf_set", 32'(bi0.overflow), 1);
        check_eq("ovf_count", log_id[0].size(), 4);
        check_eq("ovf_order0", id_at(0, 0), 2);
        check_eq("ovf_order3", id_at(0, 3), 1);
        check_eq("ovf_gap0_clear", 32'(bi1.overflow), 0);
        check_eq("ovf_gap0_count", log_id[1].size(), 5);
        btn_r = '0; wait_cycles(20);

        // Reset asserted during FIRE with pending 1010.
        clear_logs(); btn_r = 4'b1010; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #2;
            if (bi0.pulse === 1'b1) found = 1'b1;
        end
        check_eq("rst_fire_seen", 32'(found), 1);
        check_eq("rst_fire_id", 32'(bi0.pulse_id), 3);
        check_eq("rst_fire_pending", 32'(bi0.pending), 4'b1010);
        reset = 1'b1; model_reset(); #1;
        check_eq("midrst_pulse",    32'(bi0.pulse),    0);
        check_eq("midrst_pending",  32'(bi0.pending),  0);
        check_eq("midrst_overflow", 32'(bi0.overflow), 0);
        check_eq("midrst_pulse_g0", 32'(bi1.pulse),    0);
        btn_r = '0; wait_cycles(2); reset = 1'b0; wait_cycles(5);

        // All four together after reset: rotation 0,1,2,3 with period GAP+2.
        clear_logs(); btn_r = 4'b1111; wait_cycles(30);
        check_eq("rr_count", log_id[0].size(), 4);
        for (int k = 0; k < 4; k++) check_eq("rr_order", id_at(0, k), k);
        for (int k = 1; k < 4; k++) check_eq("rr_spacing_g2", cyc_at(0, k) - cyc_at(0, k-1), 4);
        for (int k = 1; k < 4; k++) check_eq("rr_spacing_g0", cyc_at(1, k) - cyc_at(1, k-1), 2);
        btn_r = '0; wait_cycles(20);
        clear_logs(); btn_r = 4'b1001; wait_cycles(25);
        check_eq("rr2_first", id_at(0, 0), 0);
        check_eq("rr2_second", id_at(0, 1), 3);
        btn_r = '0; wait_cycles(20);

        // Set-wins: button 3 re-press lands in its own FIRE cycle.
        clear_logs(); btn_r = 4'b1111;
        wait_cycles(4); btn_r[3] = 1'b0; wait_cycles(10); btn_r[3] = 1'b1; wait_cycles(35);
        check_eq("setwin_count", log_id[0].size(), 5);
        check_eq("setwin_id3", id_at(0, 3), 3);
        check_eq("setwin_id4", id_at(0, 4), 3);
        check_eq("setwin_spacing", cyc_at(0, 4) - cyc_at(0, 3), 4);
        check_eq("setwin_overflow", 32'(bi0.overflow), 0);
        btn_r = '0; wait_cycles(20);

        // Random button activity, one random reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c == 700) begin
                reset = 1'b1; model_reset(); #1;
                check_eq("rand_rst_pulse", 32'(bi0.pulse), 0);
                @(negedge clk); reset = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) btn_r[i] = ~btn_r[i];
        end
        btn_r = '0; wait_cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
